// File: rtl/llfifo_mq.sv
// llfifo_mq: multi-queue FIFO with one shared data pool.
//
// ID_N logical queues are singly linked lists threaded through a pool of PTR_N
// slots. Unused slots form a separate free list. Every cycle the block accepts
// one push and one pop (to any queues), or a single-cycle flush of one queue.
// After reset the block spends PTR_N cycles building the free list (busy=1).
//
// Ports
//   clk, rst                   clock; synchronous active-low reset
//   push_vld/push_id/push_dat  push request; push_rdy accepts it
//   pop_vld/pop_id             pop request; pop_rdy accepts it
//   pop_dat_vld/pop_dat/       registered pop response, one cycle after the
//     pop_dat_id               pop is accepted
//   flush/flush_id             empty one queue (blocks push/pop that cycle)
//   cnt                        per-queue occupancy, queue i at [i*CW +: CW]
//   nempty                     bit i set when queue i holds data
//   free_cnt                   free slots in the pool
//   full/empty/busy            pool status; busy while building the free list
module llfifo_mq #(
    parameter int unsigned W     = 32,
    parameter int unsigned ID_N  = 4,
    parameter int unsigned PTR_N = 16,
    localparam int unsigned PW   = $clog2(PTR_N),
    localparam int unsigned IW   = $clog2(ID_N),
    localparam int unsigned CW   = $clog2(PTR_N + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_vld,
    input  logic [IW-1:0]      push_id,
    input  logic [W-1:0]       push_dat,
    output logic               push_rdy,
    input  logic               pop_vld,
    input  logic [IW-1:0]      pop_id,
    output logic               pop_rdy,
    output logic               pop_dat_vld,
    output logic [W-1:0]       pop_dat,
    output logic [IW-1:0]      pop_dat_id,
    input  logic               flush,
    input  logic [IW-1:0]      flush_id,
    output logic [ID_N*CW-1:0] cnt,
    output logic [ID_N-1:0]    nempty,
    output logic [CW-1:0]      free_cnt,
    output logic               full,
    output logic               empty,
    output logic               busy
);

    typedef enum logic {StInit, StIdle} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] icnt_q, icnt_d;

    // Pool storage, deliberately not reset.
    logic [W-1:0]  dat_q [PTR_N];
    logic [PW-1:0] nxt_q [PTR_N];

    logic [PW-1:0] head_q [ID_N];
    logic [PW-1:0] head_d [ID_N];
    logic [PW-1:0] tail_q [ID_N];
    logic [PW-1:0] tail_d [ID_N];
    logic [CW-1:0] qcnt_q [ID_N];
    logic [CW-1:0] qcnt_d [ID_N];

    logic [PW-1:0] fhead_q, fhead_d, ftail_q, ftail_d;
    logic [CW-1:0] free_q, free_d;

    logic          rvld_q, rvld_d;
    logic [W-1:0]  rdat_q, rdat_d;
    logic [IW-1:0] rid_q, rid_d;

    // Two link write ports: one appends to a queue tail, the other appends to
    // the free-list tail (also used while initialising the pool).
    logic          link_we, rel_we, dat_we;
    logic [PW-1:0] link_addr, link_data, rel_addr, rel_data;

    logic          idle, push_acc, pop_acc;
    logic [PW-1:0] pop_h, push_p;

    assign idle     = (state_q == StIdle);
    assign push_rdy = idle & ~flush & (free_q != '0);
    assign pop_rdy  = idle & ~flush & (qcnt_q[pop_id] != '0);
    assign push_acc = push_vld & push_rdy;
    assign pop_acc  = pop_vld & pop_rdy;
    assign pop_h    = head_q[pop_id];
    assign push_p   = fhead_q;

    always_comb begin
        state_d   = state_q;
        icnt_d    = icnt_q;
        head_d    = head_q;
        tail_d    = tail_q;
        qcnt_d    = qcnt_q;
        fhead_d   = fhead_q;
        ftail_d   = ftail_q;
        free_d    = free_q;
        rvld_d    = 1'b0;
        rdat_d    = rdat_q;
        rid_d     = rid_q;
        link_we   = 1'b0;
        link_addr = '0;
        link_data = '0;
        rel_we    = 1'b0;
        rel_addr  = '0;
        rel_data  = '0;
        dat_we    = 1'b0;

        unique case (state_q)
            StInit: begin
                rel_we   = 1'b1;
                rel_addr = icnt_q;
                rel_data = icnt_q + PW'(1);
                icnt_d   = icnt_q + PW'(1);
                if (icnt_q == PW'(PTR_N - 1)) begin
                    state_d = StIdle;
                    fhead_d = '0;
                    ftail_d = PW'(PTR_N - 1);
                    free_d  = CW'(PTR_N);
                end
            end
            StIdle: begin
                if (flush) begin
                    if (qcnt_q[flush_id] != '0) begin
                        if (free_q == '0) begin
                            fhead_d = head_q[flush_id];
                        end else begin
                            rel_we   = 1'b1;
                            rel_addr = ftail_q;
                            rel_data = head_q[flush_id];
                        end
                        ftail_d          = tail_q[flush_id];
                        free_d           = free_q + qcnt_q[flush_id];
                        qcnt_d[flush_id] = '0;
                    end
                end else begin
                    if (push_acc) begin
                        fhead_d = nxt_q[fhead_q];
                    end
                    if (pop_acc) begin
                        head_d[pop_id] = nxt_q[pop_h];
                        qcnt_d[pop_id] = qcnt_q[pop_id] - CW'(1);
                        // Free list becomes empty if a push takes its last slot;
                        // the released slot then restarts it.
                        if (free_q == CW'(push_acc)) begin
                            fhead_d = pop_h;
                        end else begin
                            rel_we   = 1'b1;
                            rel_addr = ftail_q;
                            rel_data = pop_h;
                        end
                        ftail_d = pop_h;
                        rvld_d  = 1'b1;
                        rdat_d  = dat_q[pop_h];
                        rid_d   = pop_id;
                    end
                    if (push_acc) begin
                        dat_we = 1'b1;
                        // Uses post-pop count so a queue drained this cycle
                        // restarts at the pushed slot.
                        if (qcnt_d[push_id] == '0) begin
                            head_d[push_id] = push_p;
                        end else begin
                            link_we   = 1'b1;
                            link_addr = tail_q[push_id];
                            link_data = push_p;
                        end
                        tail_d[push_id] = push_p;
                        qcnt_d[push_id] = qcnt_d[push_id] + CW'(1);
                    end
                    free_d = free_q - CW'(push_acc) + CW'(pop_acc);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StInit;
            icnt_q  <= '0;
            for (int i = 0; i < ID_N; i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                qcnt_q[i] <= '0;
            end
            fhead_q <= '0;
            ftail_q <= '0;
            free_q  <= '0;
            rvld_q  <= 1'b0;
            rdat_q  <= '0;
            rid_q   <= '0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            qcnt_q  <= qcnt_d;
            fhead_q <= fhead_d;
            ftail_q <= ftail_d;
            free_q  <= free_d;
            rvld_q  <= rvld_d;
            rdat_q  <= rdat_d;
            rid_q   <= rid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (dat_we) begin
                dat_q[push_p] <= push_dat;
            end
            if (link_we) begin
                nxt_q[link_addr] <= link_data;
            end
            if (rel_we) begin
                nxt_q[rel_addr] <= rel_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push_vld) begin
            assert (32'(push_id) < ID_N);
        end
    end

    always_comb begin
        cnt    = '0;
        nempty = '0;
        for (int i = 0; i < ID_N; i++) begin
            cnt[i*CW +: CW] = qcnt_q[i];
            nempty[i]       = (qcnt_q[i] != '0);
        end
    end

    assign pop_dat_vld = rvld_q;
    assign pop_dat     = rdat_q;
    assign pop_dat_id  = rid_q;
    assign free_cnt    = free_q;
    assign full        = idle & (free_q == '0);
    assign empty       = idle & (free_q == CW'(PTR_N));
    assign busy        = ~idle;

endmodule

// File: tb/tb_llfifo_mq.sv
module tb_llfifo_mq;

    localparam int W     = 32;
    localparam int ID_N  = 4;
    localparam int PTR_N = 16;
    localparam int IW    = 2;
    localparam int CW    = 5;

    logic               clk;
    logic               rst;
    logic               push_vld;
    logic [IW-1:0]      push_id;
    logic [W-1:0]       push_dat;
    logic               push_rdy;
    logic               pop_vld;
    logic [IW-1:0]      pop_id;
    logic               pop_rdy;
    logic               pop_dat_vld;
    logic [W-1:0]       pop_dat;
    logic [IW-1:0]      pop_dat_id;
    logic               flush;
    logic [IW-1:0]      flush_id;
    logic [ID_N*CW-1:0] cnt;
    logic [ID_N-1:0]    nempty;
    logic [CW-1:0]      free_cnt;
    logic               full;
    logic               empty;
    logic               busy;

    int n_checks;
    int n_errors;

    // Reference model: one plain queue of words per logical queue.
    logic [W-1:0] mq [ID_N][$];

    llfifo_mq #(.W(W), .ID_N(ID_N), .PTR_N(PTR_N)) dut (
        .clk         (clk),
        .rst         (rst),
        .push_vld    (push_vld),
        .push_id     (push_id),
        .push_dat    (push_dat),
        .push_rdy    (push_rdy),
        .pop_vld     (pop_vld),
        .pop_id      (pop_id),
        .pop_rdy     (pop_rdy),
        .pop_dat_vld (pop_dat_vld),
        .pop_dat     (pop_dat),
        .pop_dat_id  (pop_dat_id),
        .flush       (flush),
        .flush_id    (flush_id),
        .cnt         (cnt),
        .nempty      (nempty),
        .free_cnt    (free_cnt),
        .full        (full),
        .empty       (empty),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    function automatic int total();
        int s = 0;
        for (int i = 0; i < ID_N; i++) s += mq[i].size();
        return s;
    endfunction

    function automatic logic [ID_N*CW-1:0] exp_cnt();
        logic [ID_N*CW-1:0] v = '0;
        for (int i = 0; i < ID_N; i++) v[i*CW +: CW] = CW'(mq[i].size());
        return v;
    endfunction

    function automatic logic [ID_N-1:0] exp_nempty();
        logic [ID_N-1:0] v = '0;
        for (int i = 0; i < ID_N; i++) v[i] = (mq[i].size() != 0);
        return v;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < ID_N; i++) mq[i].delete();
    endfunction

    // Drives one cycle starting just after a rising edge, updates the model at
    // the edge and returns the response the model expects right after it.
    task automatic drive_cycle(input logic pv, input logic [IW-1:0] pid,
                               input logic [W-1:0] pd, input logic ov,
                               input logic [IW-1:0] oid, input logic fl,
                               input logic [IW-1:0] fid, output logic rv,
                               output logic [W-1:0] rd, output logic [IW-1:0] rid);
        int  free;
        logic ps_ok, pp_ok;
        push_vld = pv; push_id = pid; push_dat = pd;
        pop_vld = ov; pop_id = oid; flush = fl; flush_id = fid;
        free  = PTR_N - total();
        ps_ok = pv && !fl && free > 0;
        pp_ok = ov && !fl && mq[oid].size() > 0;
        @(posedge clk);
        rv = pp_ok; rd = '0; rid = oid;
        if (fl) begin
            mq[fid].delete();
        end else begin
            if (pp_ok) rd = mq[oid].pop_front();
            if (ps_ok) mq[pid].push_back(pd);
        end
        #1;
        push_vld = 1'b0; pop_vld = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b0; push_vld = 0; pop_vld = 0; flush = 0;
        push_id = 0; push_dat = 0; pop_id = 0; flush_id = 0;
        repeat (3) @(posedge clk);
        #1;
        model_clear();
        n_checks++;
        if ({busy, push_rdy, pop_rdy, pop_dat_vld, full, empty} !== 6'b100000) begin
            n_errors++;
            $display("FAIL reset_flags: got %b want 100000",
                     {busy, push_rdy, pop_rdy, pop_dat_vld, full, empty});
        end
        n_checks++;
        if (free_cnt !== '0 || cnt !== '0 || nempty !== '0 || pop_dat !== '0 || pop_dat_id !== '0) begin
            n_errors++;
            $display("FAIL reset_values: free=%0d cnt=%h nempty=%b dat=%h id=%0d want all 0",
                     free_cnt, cnt, nempty, pop_dat, pop_dat_id);
        end
        rst = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (n != PTR_N) begin
            n_errors++;
            $display("FAIL init_cycles: got %0d want %0d", n, PTR_N);
        end
        n_checks++;
        if (push_rdy !== 1'b1 || free_cnt !== CW'(PTR_N) || empty !== 1'b1 || full !== 1'b0) begin
            n_errors++;
            $display("FAIL after_init: rdy=%b free=%0d empty=%b full=%b want 1 16 1 0",
                     push_rdy, free_cnt, empty, full);
        end
    endtask

    task automatic test_basic();
        logic rv; logic [W-1:0] rd; logic [IW-1:0] rid;
        logic [W-1:0] want [3];
        want[0] = 32'hA; want[1] = 32'hB; want[2] = 32'hC;
        for (int i = 0; i < 3; i++) drive_cycle(1, 1, want[i], 0, 0, 0, 0, rv, rd, rid);
        drive_cycle(1, 2, 32'hD, 0, 0, 0, 0, rv, rd, rid);
        n_checks++;
        if (pop_dat_vld !== 1'b0 || cnt !== exp_cnt()) begin
            n_errors++;
            $display("FAIL basic_fill: vld=%b cnt=%h want 0 %h", pop_dat_vld, cnt, exp_cnt());
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, 0, 0, 1, 1, 0, 0, rv, rd, rid);
            n_checks++;
            if (pop_dat_vld !== 1'b1 || pop_dat !== want[i] || pop_dat_id !== 2'd1 || rd !== want[i]) begin
                n_errors++;
                $display("FAIL basic_pop%0d: vld=%b dat=%h id=%0d want 1 %h 1",
                         i, pop_dat_vld, pop_dat, pop_dat_id, want[i]);
            end
        end
        drive_cycle(0, 0, 0, 0, 0, 0, 0, rv, rd, rid);
        n_checks++;
        if (pop_dat_vld !== 1'b0 || cnt[1*CW +: CW] !== 5'd0 || cnt[2*CW +: CW] !== 5'd1
            || nempty !== 4'b0100) begin
            n_errors++;
            $display("FAIL basic_counts: vld=%b cnt1=%0d cnt2=%0d nempty=%b want 0 0 1 0100",
                     pop_dat_vld, cnt[1*CW +: CW], cnt[2*CW +: CW], nempty);
        end
    endtask

    task automatic test_drain();
        logic rv; logic [W-1:0] rd; logic [IW-1:0] rid;
        for (int q = 0; q < ID_N; q++) begin
            while (mq[q].size() > 0) begin
                drive_cycle(0, 0, 0, 1, IW'(q), 0, 0, rv, rd, rid);
                n_checks++;
                if (pop_dat_vld !== 1'b1 || pop_dat !== rd || pop_dat_id !== rid) begin
                    n_errors++;
                    $display("FAIL drain_q%0d: vld=%b dat=%h id=%0d want 1 %h %0d",
                             q, pop_dat_vld, pop_dat, pop_dat_id, rd, rid);
                end
            end
        end
        n_checks++;
        if (empty !== 1'b1 || free_cnt !== CW'(PTR_N) || cnt !== '0) begin
            n_errors++;
            $display("FAIL drain_empty: empty=%b free=%0d cnt=%h want 1 16 0", empty, free_cnt, cnt);
        end
    endtask

    task automatic test_full();
        logic rv; logic [W-1:0] rd; logic [IW-1:0] rid;
        logic [W-1:0] first, extra;
        for (int i = 0; i < PTR_N; i++) drive_cycle(1, 0, $urandom, 0, 0, 0, 0, rv, rd, rid);
        first = mq[0][0];
        n_checks++;
        if (full !== 1'b1 || push_rdy !== 1'b0 || free_cnt !== 5'd0) begin
            n_errors++;
            $display("FAIL full_flag: full=%b rdy=%b free=%0d want 1 0 0", full, push_rdy, free_cnt);
        end
        // Push stalls while full; pop still proceeds in the same cycle.
        extra = $urandom;
        drive_cycle(1, 0, extra, 1, 0, 0, 0, rv, rd, rid);
        n_checks++;
        if (pop_dat_vld !== 1'b1 || pop_dat !== first || cnt[0 +: CW] !== 5'd15) begin
            n_errors++;
            $display("FAIL full_pushpop: vld=%b dat=%h cnt0=%0d want 1 %h 15",
                     pop_dat_vld, pop_dat, cnt[0 +: CW], first);
        end
        drive_cycle(1, 0, extra, 0, 0, 0, 0, rv, rd, rid);
        n_checks++;
        if (cnt[0 +: CW] !== 5'd16 || free_cnt !== 5'd0 || full !== 1'b1) begin
            n_errors++;
            $display("FAIL full_refill: cnt0=%0d free=%0d full=%b want 16 0 1",
                     cnt[0 +: CW], free_cnt, full);
        end
        drive_cycle(0, 0, 0, 1, 0, 0, 0, rv, rd, rid);
        // One free slot: the pushed word takes it and the popped slot refills the list.
        drive_cycle(1, 0, $urandom, 1, 0, 0, 0, rv, rd, rid);
        n_checks++;
        if (pop_dat !== rd || cnt[0 +: CW] !== 5'd15 || free_cnt !== 5'd1) begin
            n_errors++;
            $display("FAIL free1_pushpop: dat=%h cnt0=%0d free=%0d want %h 15 1",
                     pop_dat, cnt[0 +: CW], free_cnt, rd);
        end
        drive_cycle(1, 1, $urandom, 0, 0, 0, 0, rv, rd, rid);
        test_drain();
    endtask

    task automatic test_same_queue_one();
        logic rv; logic [W-1:0] rd; logic [IW-1:0] rid;
        logic [W-1:0] old;
        old = $urandom;
        drive_cycle(1, 3, old, 0, 0, 0, 0, rv, rd, rid);
        drive_cycle(1, 3, 32'h55, 1, 3, 0, 0, rv, rd, rid);
        n_checks++;
        if (pop_dat !== old || pop_dat_id !== 2'd3 || cnt[3*CW +: CW] !== 5'd1) begin
            n_errors++;
            $display("FAIL q3_swap: dat=%h id=%0d cnt3=%0d want %h 3 1",
                     pop_dat, pop_dat_id, cnt[3*CW +: CW], old);
        end
        drive_cycle(0, 0, 0, 1, 3, 0, 0, rv, rd, rid);
        n_checks++;
        if (pop_dat_vld !== 1'b1 || pop_dat !== 32'h55 || cnt[3*CW +: CW] !== 5'd0) begin
            n_errors++;
            $display("FAIL q3_second: vld=%b dat=%h cnt3=%0d want 1 55 0",
                     pop_dat_vld, pop_dat, cnt[3*CW +: CW]);
        end
    endtask

    task automatic test_flush();
        logic rv; logic [W-1:0] rd; logic [IW-1:0] rid;
        int r;
        logic [IW-1:0] q;
        for (int i = 0; i < 6; i++) drive_cycle(1, 0, $urandom, 0, 0, 0, 0, rv, rd, rid);
        for (int i = 0; i < 3; i++) drive_cycle(1, 1, $urandom, 0, 0, 0, 0, rv, rd, rid);
        drive_cycle(0, 0, 0, 1, 0, 0, 0, rv, rd, rid);
        n_checks++;
        if (pop_dat_vld !== 1'b1 || pop_dat !== rd) begin
            n_errors++;
            $display("FAIL flush_prepop: vld=%b dat=%h want 1 %h", pop_dat_vld, pop_dat, rd);
        end
        // Flush q0 (5 left) while a push and a pop are also presented.
        drive_cycle(1, 2, $urandom, 1, 1, 1, 0, rv, rd, rid);
        n_checks++;
        if (cnt[0 +: CW] !== 5'd0 || free_cnt !== 5'd13 || pop_dat_vld !== 1'b0
            || cnt !== exp_cnt()) begin
            n_errors++;
            $display("FAIL flush_q0: cnt=%h free=%0d vld=%b want %h 13 0",
                     cnt, free_cnt, pop_dat_vld, exp_cnt());
        end
        drive_cycle(0, 0, 0, 0, 0, 1, 2, rv, rd, rid);
        n_checks++;
        if (cnt !== exp_cnt() || free_cnt !== 5'd13) begin
            n_errors++;
            $display("FAIL flush_empty_noop: cnt=%h free=%0d want %h 13", cnt, free_cnt, exp_cnt());
        end
        for (int i = 0; i < 13; i++) begin
            r = $urandom_range(0, 2);
            q = (r == 0) ? 2'd0 : ((r == 1) ? 2'd2 : 2'd3);
            drive_cycle(1, q, $urandom, 0, 0, 0, 0, rv, rd, rid);
        end
        n_checks++;
        if (full !== 1'b1 || free_cnt !== 5'd0 || total() != PTR_N) begin
            n_errors++;
            $display("FAIL flush_refill: full=%b free=%0d want 1 0", full, free_cnt);
        end
        test_drain();
    endtask

    task automatic test_random();
        logic rv; logic [W-1:0] rd; logic [IW-1:0] rid;
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 2) != 0, IW'($urandom), $urandom,
                        $urandom_range(0, 1) != 0, IW'($urandom),
                        $urandom_range(0, 19) == 0, IW'($urandom), rv, rd, rid);
            n_checks++;
            if (pop_dat_vld !== rv || (rv && (pop_dat !== rd || pop_dat_id !== rid))) begin
                n_errors++;
                $display("FAIL rand_resp[%0d]: vld=%b dat=%h id=%0d want %b %h %0d",
                         i, pop_dat_vld, pop_dat, pop_dat_id, rv, rd, rid);
            end
            n_checks++;
            if (cnt !== exp_cnt() || nempty !== exp_nempty()
                || free_cnt !== CW'(PTR_N - total())) begin
                n_errors++;
                $display("FAIL rand_state[%0d]: cnt=%h nempty=%b free=%0d want %h %b %0d",
                         i, cnt, nempty, free_cnt, exp_cnt(), exp_nempty(), PTR_N - total());
            end
        end
        test_drain();
    endtask

    task automatic test_reset_midstream();
        logic rv; logic [W-1:0] rd; logic [IW-1:0] rid;
        int n;
        for (int i = 0; i < 3; i++) drive_cycle(1, 2, $urandom, 0, 0, 0, 0, rv, rd, rid);
        pop_vld = 1'b1; pop_id = 2; rst = 1'b0;
        @(posedge clk);
        #1;
        pop_vld = 1'b0;
        model_clear();
        n_checks++;
        if (pop_dat_vld !== 1'b0 || busy !== 1'b1 || cnt !== '0 || free_cnt !== '0) begin
            n_errors++;
            $display("FAIL midreset: vld=%b busy=%b cnt=%h free=%0d want 0 1 0 0",
                     pop_dat_vld, busy, cnt, free_cnt);
        end
        rst = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (n != PTR_N || free_cnt !== CW'(PTR_N) || cnt !== '0) begin
            n_errors++;
            $display("FAIL midreset_init: cycles=%0d free=%0d cnt=%h want 16 16 0", n, free_cnt, cnt);
        end
        drive_cycle(1, 1, 32'h1234, 0, 0, 0, 0, rv, rd, rid);
        drive_cycle(0, 0, 0, 1, 1, 0, 0, rv, rd, rid);
        n_checks++;
        if (pop_dat_vld !== 1'b1 || pop_dat !== 32'h1234) begin
            n_errors++;
            $display("FAIL midreset_reuse: vld=%b dat=%h want 1 1234", pop_dat_vld, pop_dat);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_basic();
        test_drain();
        test_full();
        test_same_queue_one();
        test_flush();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
